// File: rtl/window_shift_buffer.sv
// WIN x WIN sliding pixel window: full raster load, or a one-cycle left/right/down shift
// followed by a valid/ready refill of the vacated column or row.
module window_shift_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 3
) (
    input  logic                        clk_i,
    input  logic                        n_rst_i,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [1:0]                  shift_direc_i,
    input  logic                        data_valid_i,
    input  logic [DATA_W-1:0]           data_r_i,
    output logic                        data_ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        window_valid_o,
    output logic [WIN*WIN*DATA_W-1:0]   window_o
);

    localparam int unsigned N    = WIN * WIN;
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StShift, StFill, StDone} state_e;
    typedef enum logic [1:0] {DirLoad = 2'b00, DirLeft = 2'b01, DirRight = 2'b10,
                              DirDown = 2'b11} dir_e;

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   tgt_q, tgt_d;
    logic              loaded_q, loaded_d;
    logic              valid_q, valid_d;

    logic [N*DATA_W-1:0] win_flat;
    logic                shift_en;
    logic                fill_en;
    int unsigned         slot;

    assign shift_en = (state_q == StShift);
    assign fill_en  = (state_q == StFill) && data_valid_i;

    // Window entry written by the current fill beat.
    always_comb begin
        slot = 32'(cnt_q);
        case (dir_q)
            DirLeft:  slot = 32'(cnt_q) * WIN + (WIN - 1);
            DirRight: slot = 32'(cnt_q) * WIN;
            default:  slot = 32'(cnt_q);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        loaded_d = loaded_q;
        valid_d  = valid_q;
        if (clear_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            loaded_d = 1'b0;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        valid_d = 1'b0;
                        dir_d   = dir_e'(shift_direc_i);
                        cnt_d   = '0;
                        if (shift_direc_i == DirLoad) begin
                            tgt_d   = CntW'(N);
                            state_d = StFill;
                        end else begin
                            tgt_d   = CntW'(WIN);
                            state_d = StShift;
                        end
                    end
                end
                StShift: begin
                    cnt_d   = '0;
                    state_d = StFill;
                end
                StFill: begin
                    if (data_valid_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == tgt_q - 1'b1) begin
                            state_d  = StDone;
                            loaded_d = loaded_q || (dir_q == DirLoad);
                            valid_d  = loaded_q || (dir_q == DirLoad);
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q  <= StIdle;
            dir_q    <= DirLoad;
            cnt_q    <= '0;
            tgt_q    <= '0;
            loaded_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            loaded_q <= loaded_d;
            valid_q  <= valid_d;
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            localparam int unsigned Idx = r * WIN + c;

            logic [DATA_W-1:0] pix_q, pix_d;
            logic [DATA_W-1:0] from_right, from_left, from_up;

            // Neighbour sources; edge entries take zero when their neighbour falls off.
            if (c < WIN - 1) begin : g_r
                assign from_right = win_flat[(Idx+1)*DATA_W +: DATA_W];
            end else begin : g_r0
                assign from_right = '0;
            end
            if (c > 0) begin : g_l
                assign from_left = win_flat[(Idx-1)*DATA_W +: DATA_W];
            end else begin : g_l0
                assign from_left = '0;
            end
            if (r > 0) begin : g_u
                assign from_up = win_flat[(Idx-WIN)*DATA_W +: DATA_W];
            end else begin : g_u0
                assign from_up = '0;
            end

            always_comb begin
                pix_d = pix_q;
                if (clear_i) begin
                    pix_d = '0;
                end else if (shift_en) begin
                    case (dir_q)
                        DirLeft:  pix_d = from_right;
                        DirRight: pix_d = from_left;
                        DirDown:  pix_d = from_up;
                        default:  pix_d = pix_q;
                    endcase
                end else if (fill_en && (slot == Idx)) begin
                    pix_d = data_r_i;
                end
            end

            always_ff @(posedge clk_i or negedge n_rst_i) begin
                if (!n_rst_i) begin
                    pix_q <= '0;
                end else begin
                    pix_q <= pix_d;
                end
            end

            assign win_flat[Idx*DATA_W +: DATA_W] = pix_q;
        end
    end

    assign data_ready_o   = (state_q == StFill);
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign window_valid_o = valid_q;
    assign window_o       = win_flat;

endmodule
